nns_stream_loader: RTL

- Upstream feeder for the combinational first-nearest-neighbour search stage.
- Accepts one query point followed by N element points as a serial stream on a valid/ready handshake.
- Packs the points into the wide query and element buses that the search stage reads. Holds those buses stable, captures the search result, and returns it on an output valid/ready handshake.
- One search frame is processed at a time; there is no overlap between frames.

---
 rtl/nns_stream_loader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/nns_stream_loader.sv
// nns_stream_loader
//   Serial front end for the combinational first-nearest-neighbour search
//   stage. A frame arrives as one query point followed by N element points
//   on a valid/ready stream. The points are packed into the wide g_bus/e_bus
//   registers that the search stage reads. The search result is captured
//   one cycle after the last element, and it is returned on a valid/ready
//   output. Only one frame is in flight at a time.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   in_valid/ready  input handshake; in_data = {x, y}, x in the upper half
//   g_bus           registered query point for the search stage
//   e_bus           registered element points, slot i at [2W(i+1)-1 : 2W*i]
//   nn_result       nearest element returned by the search stage
//   out_valid/ready output handshake; out_data = captured nearest element
//   busy            low only while waiting for a query point
module nns_stream_loader #(
  parameter int W = 15,
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   in_data,
  output logic [2*W-1:0]   g_bus,
  output logic [2*W*N-1:0] e_bus,
  input  logic [2*W-1:0]   nn_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_data,
  output logic             busy
);

  localparam int PW = 2 * W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    LOAD_Q = 2'd0,
    LOAD_E = 2'd1,
    EVAL   = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     g_q, g_d;
  logic [PW*N-1:0]   e_q, e_d;
  logic [PW-1:0]     od_q, od_d;
  logic              ov_q, ov_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_Q;
      cnt_q   <= '0;
      g_q     <= '0;
      e_q     <= '0;
      od_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      e_q     <= e_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    g_d      = g_q;
    e_d      = e_q;
    od_d     = od_q;
    ov_d     = ov_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      LOAD_Q: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          g_d     = in_data;
          cnt_d   = '0;
          state_d = LOAD_E;
        end
      end
      LOAD_E: begin
        in_ready = 1'b1;
        if (in_valid) begin
          e_d[cnt_q*PW +: PW] = in_data;
          // Counter holds at the last slot so it never indexes past N-1.
          if (cnt_q == LAST) begin
            state_d = EVAL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EVAL: begin
        // Buses have been stable for this whole cycle, so the
        // combinational search result is settled by the closing edge.
        od_d    = nn_result;
        ov_d    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = LOAD_Q;
        end
      end
      default: begin
        state_d = LOAD_Q;
      end
    endcase
  end

  assign g_bus     = g_q;
  assign e_bus     = e_q;
  assign out_data  = od_q;
  assign out_valid = ov_q;

endmodule
